// File: rtl/id_pkg.sv
// Shared types for the decode-to-execute stage.
// Register-index widths, opcode encoding and stage bundles.
package id_pkg;

    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;
    localparam int ARQ_W    = 16;
    localparam int OPC_W    = 5;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_AND = 5'd3,
        OP_OR  = 5'd4,
        OP_XOR = 5'd5,
        OP_LD  = 5'd6,
        OP_ST  = 5'd7
    } opcode_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dst;
        logic [ARQ_W-1:0]  imm;
        logic              wr;
    } id_bundle_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] dst;
        logic [ARQ_W-1:0]  imm;
        logic              wr;
    } id_ex_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_AW-1:0] idx
    );
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard with combinational RAW hazard detect.
// SB_BYPASS_EN: a retiring writeback hides its own bit from the hazard check.
module id_scoreboard
    import id_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  logic [REG_AW-1:0]   set_idx_i,
    input  logic                clr_en_i,
    input  logic [REG_AW-1:0]   clr_idx_i,
    input  logic [NUM_REGS-1:0] flush_clr_i,
    input  logic [REG_AW-1:0]   src1_i,
    input  logic [REG_AW-1:0]   src2_i,
    input  logic [REG_AW-1:0]   src3_i,
    output logic                hazard_o
);

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic [NUM_REGS-1:0] busy;

    // Next scoreboard: clears first, then the issuing writer's set wins.
    always_comb begin
        sb_d = sb_q;
        if (clr_en_i) begin
            sb_d = sb_d & ~reg_onehot(clr_idx_i);
        end
        sb_d = sb_d & ~flush_clr_i;
        if (set_en_i) begin
            sb_d = sb_d | reg_onehot(set_idx_i);
        end
    end

    // Bits that still block a reader this cycle.
    always_comb begin
`ifdef SB_BYPASS_EN
        busy = sb_q;
        if (clr_en_i) begin
            busy = sb_q & ~reg_onehot(clr_idx_i);
        end
`else
        busy = sb_q;
`endif
        hazard_o = busy[src1_i] | busy[src2_i] | busy[src3_i];
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute stage: S0 waits on the bank read, S1 feeds EX.
// Optional same-cycle writeback bypass of the scoreboard: SB_BYPASS_EN.
module id_ex_pipe_reg
    import id_pkg::*;
#(
    parameter int ARQ = ARQ_W,
    parameter int OPW = OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [ARQ-1:0]    id_imm,
    input  logic              id_wr,
    output logic              rb_read_en,
    input  logic [ARQ-1:0]    rb_src1_data,
    input  logic [ARQ-1:0]    rb_src2_data,
    input  logic [ARQ-1:0]    rb_src3_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OPW-1:0]    ex_opcode,
    output logic [ARQ-1:0]    ex_op1,
    output logic [ARQ-1:0]    ex_op2,
    output logic [ARQ-1:0]    ex_op3,
    output logic [ARQ-1:0]    ex_imm,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_wr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dst
);

    id_bundle_t          id_b;
    id_ex_t              s0_q, s0_d, s1_q, s1_d;
    logic                s0_v_q, s0_v_d, s1_v_q, s1_v_d;
    logic [ARQ-1:0]      op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic                hazard, ex_fire, s0_adv, accept;
    logic [NUM_REGS-1:0] flush_clr;

    assign id_b = '{opcode: id_opcode, src1: id_src1, src2: id_src2,
                    dst: id_dst, imm: id_imm, wr: id_wr};

    assign ex_fire    = s1_v_q & ex_ready;
    assign s0_adv     = s0_v_q & (~s1_v_q | ex_ready);
    assign id_ready   = ~flush & ~hazard & (~s0_v_q | s0_adv);
    assign accept     = id_valid & id_ready;
    assign rb_read_en = accept;

    assign ex_valid  = s1_v_q;
    assign ex_opcode = s1_q.opcode;
    assign ex_imm    = s1_q.imm;
    assign ex_dst    = s1_q.dst;
    assign ex_wr     = s1_q.wr;
    assign ex_op1    = op1_q;
    assign ex_op2    = op2_q;
    assign ex_op3    = op3_q;

    // On flush, release the bits of writers being killed; a handshaked S1 survives.
    always_comb begin
        flush_clr = '0;
        if (flush && s0_v_q && s0_q.wr) begin
            flush_clr = flush_clr | reg_onehot(s0_q.dst);
        end
        if (flush && s1_v_q && s1_q.wr && !ex_ready) begin
            flush_clr = flush_clr | reg_onehot(s1_q.dst);
        end
    end

    id_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (accept & id_wr),
        .set_idx_i   (id_dst),
        .clr_en_i    (wb_en),
        .clr_idx_i   (wb_dst),
        .flush_clr_i (flush_clr),
        .src1_i      (id_src1),
        .src2_i      (id_src2),
        .src3_i      (id_dst),
        .hazard_o    (hazard)
    );

    // Next state for S0 and S1; flush kills both valids.
    always_comb begin
        s0_v_d = s0_v_q;
        s0_d   = s0_q;
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        op3_d  = op3_q;
        if (s0_adv) begin
            s0_v_d = 1'b0;
        end
        if (accept) begin
            s0_v_d = 1'b1;
            s0_d   = '{opcode: id_b.opcode, dst: id_b.dst,
                       imm: id_b.imm, wr: id_b.wr};
        end
        if (ex_fire) begin
            s1_v_d = 1'b0;
        end
        if (s0_adv) begin
            s1_v_d = 1'b1;
            s1_d   = s0_q;
            op1_d  = rb_src1_data;
            op2_d  = rb_src2_data;
            op3_d  = rb_src3_data;
        end
        if (flush) begin
            s0_v_d = 1'b0;
            s1_v_d = 1'b0;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v_q <= 1'b0;
            s1_v_q <= 1'b0;
            s0_q   <= '0;
            s1_q   <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            op3_q  <= '0;
        end else begin
            s0_v_q <= s0_v_d;
            s1_v_q <= s1_v_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            op1_q  <= op1_d;
            op2_q  <= op2_d;
            op3_q  <= op3_d;
        end
    end

endmodule
